// File: rtl/kuznechik_arbiter.sv
`default_nettype none
// =============================================================================
// kuznechik_arbiter : round-robin arbiter for two requesters sharing one
//                     kuznechik_cipher core. Optional watchdog: KUZ_ARB_WATCHDOG_EN.
// Revision: 1.0
// =============================================================================
module kuznechik_arbiter #(
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic         clk_i,
  input  logic         resetn,
  input  logic         req0_i,
  input  logic [127:0] data0_i,
  output logic         ready0_o,
  output logic         valid0_o,
  output logic [127:0] data0_o,
  input  logic         ack0_i,
  input  logic         req1_i,
  input  logic [127:0] data1_i,
  output logic         ready1_o,
  output logic         valid1_o,
  output logic [127:0] data1_o,
  input  logic         ack1_i,
  output logic         core_request_o,
  output logic         core_ack_o,
  output logic [127:0] core_data_o,
  input  logic         core_busy_i,
  input  logic         core_valid_i,
  input  logic [127:0] core_data_i,
  output logic         grant_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_DELIVER = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        pending_q, pending_d;
  logic [1:0][127:0] hold_q, hold_d;
  logic [1:0][127:0] result_q, result_d;
  logic [1:0]        valid_q, valid_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              core_request_q, core_request_d;
  logic              core_ack_q, core_ack_d;
  logic [127:0]      core_data_q, core_data_d;
  logic              winner;
  logic              owner_ack;

`ifdef KUZ_ARB_WATCHDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;
`else
  // Keeps the parameter referenced when the watchdog is compiled out.
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = |WDOG_CYCLES;
`endif

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    hold_d         = hold_q;
    result_d       = result_q;
    valid_d        = valid_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    core_request_d = core_request_q;
    core_ack_d     = core_ack_q;
    core_data_d    = core_data_q;
    winner         = (&pending_q) ? ~last_grant_q : pending_q[1];
    owner_ack      = grant_q ? ack1_i : ack0_i;

    // A busy holding register ignores new requests; ready is simply !pending.
    if (req0_i && !pending_q[0]) begin
      hold_d[0]    = data0_i;
      pending_d[0] = 1'b1;
    end
    if (req1_i && !pending_q[1]) begin
      hold_d[1]    = data1_i;
      pending_d[1] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        core_ack_d = 1'b0;
        if (|pending_q) begin
          state_d        = ST_ISSUE;
          last_grant_d   = winner;
          grant_d        = winner;
          core_data_d    = hold_q[winner];
          core_request_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        // The core registers its next state, so request stays up until busy.
        if (core_busy_i) begin
          core_request_d = 1'b0;
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_valid_i) begin
          result_d[grant_q] = core_data_i;
          core_ack_d        = 1'b1;
          state_d           = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!core_valid_i) begin
          core_ack_d       = 1'b0;
          valid_d[grant_q] = 1'b1;
          state_d          = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (owner_ack) begin
          valid_d[grant_q]   = 1'b0;
          pending_d[grant_q] = 1'b0;
          state_d            = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef KUZ_ARB_WATCHDOG_EN
    wdog_d = wdog_q;
    err_d  = err_q;
    if (state_q == ST_IDLE) begin
      wdog_d = '0;
    end else if (state_q != ST_DELIVER) begin
      wdog_d = wdog_q + 16'd1;
      if (wdog_q == WDOG_LAST) begin
        // Abandon the transaction; the ack pulse frees a core stuck in FINISH.
        err_d              = 1'b1;
        core_request_d     = 1'b0;
        core_ack_d         = 1'b1;
        pending_d[grant_q] = 1'b0;
        valid_d[grant_q]   = 1'b0;
        result_d[grant_q]  = result_q[grant_q];
        state_d            = ST_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      hold_q         <= '0;
      result_q       <= '0;
      valid_q        <= '0;
      last_grant_q   <= 1'b1;
      grant_q        <= 1'b0;
      core_request_q <= 1'b0;
      core_ack_q     <= 1'b0;
      core_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      hold_q         <= hold_d;
      result_q       <= result_d;
      valid_q        <= valid_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      core_request_q <= core_request_d;
      core_ack_q     <= core_ack_d;
      core_data_q    <= core_data_d;
    end
  end

`ifdef KUZ_ARB_WATCHDOG_EN
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign ready0_o       = ~pending_q[0];
  assign ready1_o       = ~pending_q[1];
  assign valid0_o       = valid_q[0];
  assign valid1_o       = valid_q[1];
  assign data0_o        = result_q[0];
  assign data1_o        = result_q[1];
  assign core_request_o = core_request_q;
  assign core_ack_o     = core_ack_q;
  assign core_data_o    = core_data_q;
  assign grant_o        = grant_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule
`default_nettype wire
